// File: rtl/t_ff_array.sv
// Bank of WIDTH toggle flip-flops that works as an independent toggle register
// or as a cascaded T-FF up/down counter, with parallel load, terminal count and change mask.
module t_ff_array #(
  parameter int              WIDTH    = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int              SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic [WIDTH-1:0] chg
);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_UP     = 2'b10;
  localparam logic [1:0] MODE_DOWN   = 2'b11;
  localparam bit         SAT         = (SATURATE != 0);

  logic [WIDTH-1:0] up_tog;
  logic [WIDTH-1:0] dn_tog;
  logic [WIDTH-1:0] q_next;
  logic             tc_next;
  logic             at_max;
  logic             at_min;

  // Cascade toggle enables: bit i flips when all lower bits are at the carry/borrow value.
  assign up_tog[0] = 1'b1;
  assign dn_tog[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_cascade
    assign up_tog[i] = &q[i-1:0];
    assign dn_tog[i] = ~|q[i-1:0];
  end

  assign at_max = &q;
  assign at_min = ~|q;

  always_comb begin
    q_next  = q;
    tc_next = 1'b0;
    if (load) begin
      q_next = d;
    end else if (en) begin
      case (mode)
        MODE_TOGGLE: q_next = q ^ t;
        MODE_UP: begin
          tc_next = at_max;
          if (!(SAT && at_max)) q_next = q ^ up_tog;
        end
        MODE_DOWN: begin
          tc_next = at_min;
          if (!(SAT && at_min)) q_next = q ^ dn_tog;
        end
        MODE_HOLD: q_next = q;
        default:   q_next = q;
      endcase
    end
  end

  // chg is computed from the same q_next so it always lines up with the registered q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= RST_VAL;
      tc  <= 1'b0;
      chg <= '0;
    end else begin
      q   <= q_next;
      tc  <= tc_next;
      chg <= q_next ^ q;
    end
  end

endmodule

// File: tb/tb_t_ff_array.sv
// Directed self-checking bench for t_ff_array: wrapping, saturating and
// non-zero-reset-value instances share one stimulus stream.
module tb_t_ff_array;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] t;
  logic       load;
  logic [3:0] d;

  logic [3:0] q_w, chg_w, q_s, chg_s, q_r, chg_r;
  logic       tc_w, tc_s, tc_r;

  int errors = 0;
  int checks = 0;

  t_ff_array #(.WIDTH(4), .RST_VAL(4'b0000), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .load(load), .d(d),
    .q(q_w), .tc(tc_w), .chg(chg_w));

  t_ff_array #(.WIDTH(4), .RST_VAL(4'b0000), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .load(load), .d(d),
    .q(q_s), .tc(tc_s), .chg(chg_s));

  t_ff_array #(.WIDTH(4), .RST_VAL(4'b1001), .SATURATE(0)) u_rv (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .load(load), .d(d),
    .q(q_r), .tc(tc_r), .chg(chg_r));

  // Rising edges at 7, 17, 27, ... so the 15 ns reset release sits between edges.
  initial begin
    clk = 1'b0;
    #2;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; mode = 2'b00; t = 4'b0000; load = 1'b0; d = 4'b0000;
    #10;
    checks++; if (q_w !== 4'b0000) begin errors++; $display("[TB] FAIL reset_q got=%b exp=0000", q_w); end
    checks++; if (q_r !== 4'b1001) begin errors++; $display("[TB] FAIL reset_rstval_q got=%b exp=1001", q_r); end
    checks++; if (tc_w !== 1'b0 || chg_w !== 4'b0000) begin errors++; $display("[TB] FAIL reset_tc_chg got=%b/%b exp=0/0000", tc_w, chg_w); end
    #5 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q_w !== 4'b0000 || tc_w !== 1'b0 || chg_w !== 4'b0000) begin
        errors++; $display("[TB] FAIL hold_after_reset[%0d] got q=%b tc=%b chg=%b exp 0000/0/0000", i, q_w, tc_w, chg_w);
      end
    end
    load = 1'b1; d = 4'b0101;
    tick();
    load = 1'b0;
    checks++; if (q_w !== 4'b0101) begin errors++; $display("[TB] FAIL load_0101 got=%b exp=0101", q_w); end
    #2 rst = 1'b1;
    #1;
    checks++; if (q_w !== 4'b0000 || chg_w !== 4'b0000) begin errors++; $display("[TB] FAIL async_reset got q=%b chg=%b exp 0000/0000", q_w, chg_w); end
    #1 rst = 1'b0;
  endtask

  task automatic test_toggle;
    mode = 2'b01; en = 1'b1; t = 4'b1010;
    tick();
    checks++; if (q_w !== 4'b1010 || chg_w !== 4'b1010 || tc_w !== 1'b0) begin errors++; $display("[TB] FAIL toggle1 got q=%b chg=%b tc=%b exp 1010/1010/0", q_w, chg_w, tc_w); end
    tick();
    checks++; if (q_w !== 4'b0000 || chg_w !== 4'b1010 || tc_w !== 1'b0) begin errors++; $display("[TB] FAIL toggle2 got q=%b chg=%b tc=%b exp 0000/1010/0", q_w, chg_w, tc_w); end
    t = 4'b0001;
    tick();
    checks++; if (q_w !== 4'b0001 || chg_w !== 4'b0001 || tc_w !== 1'b0) begin errors++; $display("[TB] FAIL toggle3 got q=%b chg=%b tc=%b exp 0001/0001/0", q_w, chg_w, tc_w); end
    en = 1'b0;
  endtask

  task automatic test_count_up_wrap;
    load = 1'b1; d = 4'b1110; t = 4'bxxxx;
    tick();
    checks++; if (q_w !== 4'b1110 || chg_w !== 4'b1111) begin errors++; $display("[TB] FAIL up_load got q=%b chg=%b exp 1110/1111", q_w, chg_w); end
    load = 1'b0; mode = 2'b10; en = 1'b1;
    tick();
    checks++; if (q_w !== 4'b1111 || tc_w !== 1'b0 || chg_w !== 4'b0001) begin errors++; $display("[TB] FAIL up1 got q=%b tc=%b chg=%b exp 1111/0/0001", q_w, tc_w, chg_w); end
    tick();
    checks++; if (q_w !== 4'b0000 || tc_w !== 1'b1 || chg_w !== 4'b1111) begin errors++; $display("[TB] FAIL up_wrap got q=%b tc=%b chg=%b exp 0000/1/1111", q_w, tc_w, chg_w); end
    checks++; if (q_s !== 4'b1111 || tc_s !== 1'b1 || chg_s !== 4'b0000) begin errors++; $display("[TB] FAIL up_sat_hold got q=%b tc=%b chg=%b exp 1111/1/0000", q_s, tc_s, chg_s); end
    tick();
    checks++; if (q_w !== 4'b0001 || tc_w !== 1'b0 || chg_w !== 4'b0001) begin errors++; $display("[TB] FAIL up_after_wrap got q=%b tc=%b chg=%b exp 0001/0/0001", q_w, tc_w, chg_w); end
    en = 1'b0; t = 4'b0000;
  endtask

  task automatic test_count_down_sat;
    logic [3:0] exp_q [4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
    logic       exp_tc[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] exp_c [4] = '{4'b0011, 4'b0001, 4'b0000, 4'b0000};
    load = 1'b1; d = 4'b0010;
    tick();
    load = 1'b0; mode = 2'b11; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (q_s !== exp_q[i] || tc_s !== exp_tc[i] || chg_s !== exp_c[i]) begin
        errors++; $display("[TB] FAIL down_sat[%0d] got q=%b tc=%b chg=%b exp %b/%b/%b", i, q_s, tc_s, chg_s, exp_q[i], exp_tc[i], exp_c[i]);
      end
      if (i == 2) begin
        checks++;
        if (q_w !== 4'b1111 || tc_w !== 1'b1 || chg_w !== 4'b1111) begin
          errors++; $display("[TB] FAIL down_wrap got q=%b tc=%b chg=%b exp 1111/1/1111", q_w, tc_w, chg_w);
        end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load_priority;
    load = 1'b1; d = 4'b0011;
    tick();
    mode = 2'b10; en = 1'b1; load = 1'b1; d = 4'b0111;
    tick();
    checks++; if (q_w !== 4'b0111 || tc_w !== 1'b0 || chg_w !== 4'b0100) begin errors++; $display("[TB] FAIL load_prio got q=%b tc=%b chg=%b exp 0111/0/0100", q_w, tc_w, chg_w); end
    load = 1'b0;
    tick();
    checks++; if (q_w !== 4'b1000 || tc_w !== 1'b0 || chg_w !== 4'b1111) begin errors++; $display("[TB] FAIL load_resume got q=%b tc=%b chg=%b exp 1000/0/1111", q_w, tc_w, chg_w); end
    en = 1'b0;
  endtask

  task automatic test_enable_gating;
    logic       en_seq[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] exp_q [5] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3};
    load = 1'b1; d = 4'b0000;
    tick();
    load = 1'b0; mode = 2'b10;
    for (int i = 0; i < 5; i++) begin
      en = en_seq[i];
      tick();
      checks++;
      if (q_w !== exp_q[i]) begin errors++; $display("[TB] FAIL en_gate[%0d] got q=%b exp %b", i, q_w, exp_q[i]); end
    end
    en = 1'b0;
  endtask

  task automatic test_tc_abort;
    load = 1'b1; d = 4'b1111;
    tick();
    load = 1'b0; mode = 2'b10; en = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++; if (q_w !== 4'b0000 || tc_w !== 1'b0) begin errors++; $display("[TB] FAIL abort_reset got q=%b tc=%b exp 0000/0", q_w, tc_w); end
    #1 rst = 1'b0;
    tick();
    checks++; if (q_w !== 4'b0001 || tc_w !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_tc got q=%b tc=%b exp 0001/0", q_w, tc_w); end
    en = 1'b0;
  endtask

  task automatic test_rst_val;
    rst = 1'b1; mode = 2'b10; en = 1'b1;
    #3;
    checks++; if (q_r !== 4'b1001 || tc_r !== 1'b0 || chg_r !== 4'b0000) begin errors++; $display("[TB] FAIL rstval got q=%b tc=%b chg=%b exp 1001/0/0000", q_r, tc_r, chg_r); end
    tick();
    checks++; if (q_r !== 4'b1001) begin errors++; $display("[TB] FAIL rstval_held got q=%b exp 1001", q_r); end
    #2 rst = 1'b0;
    tick();
    checks++; if (q_r !== 4'b1010 || chg_r !== 4'b0011) begin errors++; $display("[TB] FAIL rstval_count got q=%b chg=%b exp 1010/0011", q_r, chg_r); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_count_up_wrap();
    test_count_down_sat();
    test_load_priority();
    test_enable_gating();
    test_tc_abort();
    test_rst_val();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/t_ff_array.md
Name: t_ff_array

Overview:
- Parametrised bank of WIDTH toggle flip-flops. Next generation of the single-bit T flip-flop.
- Each bit can toggle on its own T input, or the bits can be cascaded as a synchronous T-FF up/down counter.
- Also provides synchronous parallel load, terminal-count and per-bit change flags.
- Used as a general toggle register / small event counter in datapath and control logic.

Parameters:
- WIDTH, 8: number of T flip-flops (bits of q); legal range 2 to 32.
- RST_VAL, 0: value of q after reset; WIDTH bits wide.
- SATURATE, 0: counter limit handling. 0 = wrap at the limits, 1 = hold at the limits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  enable for toggle and count operations. Load ignores it.
- mode  input  2  00 = hold, 01 = independent toggle, 10 = count up, 11 = count down.
- t  input  WIDTH  per-bit toggle requests; used only in mode 01.
- load  input  1  synchronous parallel load of d into q.
- d  input  WIDTH  load data.
- q  output  WIDTH  flip-flop outputs.
- tc  output  1  terminal-count flag, registered.
- chg  output  WIDTH  registered mask of bits that changed at the last edge.

Behaviour:
- Reset: rst high forces q = RST_VAL, tc = 0, chg = 0 immediately, without waiting for clk. Outputs hold while rst is high. First update is on the first rising edge after rst falls.
- Priority at each rising edge: load, then en with mode, then hold.
- load = 1:
  - q <= d; tc <= 0; chg <= d ^ q_old.
  - en, mode and t are ignored.
- Hold: applies when en = 0 or mode = 00. q unchanged; tc <= 0; chg <= 0.
- Mode 01, independent toggle: q[i] <= q[i] ^ t[i] for every bit; tc <= 0.
- Mode 10, count up, T-FF cascade:
  - Bit 0 toggles every enabled cycle.
  - Bit i toggles when q[i-1:0] is all ones.
  - The result equals q + 1 modulo 2^WIDTH.
- Mode 11, count down: bit i toggles when q[i-1:0] is all zeros. The result equals q - 1 modulo 2^WIDTH.
- Limits: all ones for count up, all zeros for count down.
- Wrap, SATURATE = 0:
  - Up from all ones gives 0 and tc <= 1 on that same edge.
  - Down from 0 gives all ones and tc <= 1.
  - tc is a single-cycle pulse coincident with the wrapped q.
- Saturate, SATURATE = 1:
  - At the limit, q holds and chg <= 0.
  - tc <= 1 on every enabled count edge that starts at the limit, so tc stays high while counting against the limit.
  - The edge that reaches the limit sets tc <= 0.
- chg:
  - Always q_new ^ q_old, registered alongside q.
  - Valid in the same cycle as the updated q.
- Mode changes take effect at the next edge. No internal state beyond q, tc and chg.
- Reset asserted mid-count aborts any pending tc. A pulse that has not yet occurred never appears after reset.
- Only the rising edge of clk is used. X on t is ignored outside mode 01.

Test Plan (WIDTH = 4, RST_VAL = 0 unless stated):
1. Reset behaviour:
   - Stimulus: rst high for 15 ns, release, then hold with en = 0 for 3 cycles.
   - Required: q = 0000, tc = 0, chg = 0 throughout.
   - Stimulus: assert rst mid-cycle while q = 0101.
   - Required: q = 0000 before the next clk edge.
2. Independent toggle:
   - Stimulus: mode = 01, en = 1, t = 1010 for 2 cycles, then t = 0001.
   - Required: q = 1010, then 0000, then 0001; chg = 1010, 1010, 0001; tc = 0.
3. Count up with wrap (SATURATE = 0):
   - Stimulus: load d = 1110, then mode = 10, en = 1 for 3 cycles.
   - Required: q = 1111, 0000, 0001.
   - Required: tc high only in the cycle q = 0000; chg at the wrap edge = 1111.
4. Count down with saturate (SATURATE = 1):
   - Stimulus: load d = 0010, then mode = 11, en = 1 for 4 cycles.
   - Required: q = 0001, 0000, 0000, 0000.
   - Required: tc = 0, 0, 1, 1; chg = 0011, 0001, 0000, 0000.
5. Load priority:
   - Stimulus: mode = 10, en = 1, load = 1, d = 0111 at q = 0011.
   - Required: q = 0111, tc = 0, chg = 0100. Counting resumes next cycle: q = 1000, chg = 1111.
6. Enable gating and RST_VAL:
   - Stimulus: mode = 10 with en toggled 1, 0, 1, 0, 1.
   - Required: q advances only on en = 1 cycles, 0 to 1 to 1 to 2 to 2 to 3.
   - Stimulus: rerun with RST_VAL = 1001.
   - Required: q = 1001 after reset.
